tmds_channel_decoder: RTL and testbench

- Receive-side counterpart of the per-channel TMDS transmit encoder.
- Takes one word-aligned 10-bit TMDS symbol per pixel clock and classifies it as control, video guard, video, island guard or TERC4 island data.
- Recovers the 8-bit video byte, 4-bit island nibble or 2-bit control data, and reports the current period in the same 3-bit mode encoding the transmitter uses.
- Instantiated three times (CN=0,1,2) in the HDMI receive top, after the deserializer and word aligner.

---
 rtl/tmds_channel_decoder.sv | 162 ++++++++++++++++
 tb/tb_tmds_channel_decoder.sv | 277 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/tmds_channel_decoder.sv
// tmds_channel_decoder: classifies one aligned TMDS symbol per pixel clock and recovers
// video, TERC4 island or control data, reporting the period in the transmitter's mode encoding.
module tmds_channel_decoder #(
    parameter int CN = 0
) (
    input  logic       clk_pixel,
    input  logic       reset,
    input  logic [9:0] tmds,
    input  logic [1:0] expect_period,
    output logic [2:0] mode,
    output logic [7:0] video_data,
    output logic [3:0] data_island_data,
    output logic [1:0] control_data,
    output logic       symbol_error
);
    typedef enum logic [2:0] {CTRL, VGUARD, VIDEO, DGUARD_LEAD, ISLAND, DGUARD_TRAIL, TRAIL_DONE} state_t;
    localparam logic [9:0] VGUARD_SYM = (CN == 1) ? 10'b0100110011 : 10'b1011001100;
    localparam logic [9:0] DGUARD_SYM = 10'b0100110011;
    state_t     state, state_n;
    logic [4:0] pkt, pkt_n;
    logic       wrapped, wrapped_n;
    logic [2:0] mode_n;
    logic [7:0] video_n, q, vid;
    logic [3:0] did_n, terc_val;
    logic [1:0] cd_n, ctrl_val;
    logic       err_n, is_ctrl, terc_ok, is_dguard;
    always_comb begin
        is_ctrl  = 1'b1;
        ctrl_val = 2'd0;
        case (tmds)
            10'b1101010100: ctrl_val = 2'd0;
            10'b0010101011: ctrl_val = 2'd1;
            10'b0101010100: ctrl_val = 2'd2;
            10'b1010101011: ctrl_val = 2'd3;
            default:        is_ctrl  = 1'b0;
        endcase
    end
    always_comb begin
        terc_ok  = 1'b1;
        terc_val = 4'd0;
        case (tmds)
            10'b1010011100: terc_val = 4'h0;
            10'b1001100011: terc_val = 4'h1;
            10'b1011100100: terc_val = 4'h2;
            10'b1011100010: terc_val = 4'h3;
            10'b0101110001: terc_val = 4'h4;
            10'b0100011110: terc_val = 4'h5;
            10'b0110001110: terc_val = 4'h6;
            10'b0100111100: terc_val = 4'h7;
            10'b1011001100: terc_val = 4'h8;
            10'b0100111001: terc_val = 4'h9;
            10'b0110011100: terc_val = 4'hA;
            10'b1011000110: terc_val = 4'hB;
            10'b1010001110: terc_val = 4'hC;
            10'b1001110001: terc_val = 4'hD;
            10'b0101100011: terc_val = 4'hE;
            10'b1011000011: terc_val = 4'hF;
            default:        terc_ok  = 1'b0;
        endcase
    end
    assign q         = tmds[9] ? ~tmds[7:0] : tmds[7:0];
    assign vid       = {q[7:1] ^ q[6:0] ^ {7{~tmds[8]}}, q[0]};
    // channel 0 carries HSYNC/VSYNC in the guard nibble, so any 11xx TERC4 code is a guard there
    assign is_dguard = (CN == 0) ? (terc_ok && terc_val[3:2] == 2'b11) : (tmds == DGUARD_SYM);
    always_comb begin
        state_n   = state;
        pkt_n     = pkt;
        wrapped_n = wrapped;
        mode_n    = mode;
        video_n   = video_data;
        did_n     = data_island_data;
        cd_n      = control_data;
        err_n     = 1'b0;
        if (is_ctrl) begin
            state_n = CTRL;
            mode_n  = 3'd0;
            cd_n    = ctrl_val;
        end else begin
            case (state)
                CTRL: begin
                    if (expect_period == 2'd1 && tmds == VGUARD_SYM) begin
                        state_n = VGUARD;
                        mode_n  = 3'd2;
                    end else if (expect_period == 2'd2 && is_dguard) begin
                        state_n = DGUARD_LEAD;
                        mode_n  = 3'd4;
                        did_n   = (CN == 0) ? terc_val : data_island_data;
                        cd_n    = (CN == 0) ? terc_val[1:0] : control_data;
                    end else begin
                        err_n = 1'b1;
                    end
                end
                VGUARD: begin
                    state_n = (tmds == VGUARD_SYM) ? VIDEO : CTRL;
                    mode_n  = (tmds == VGUARD_SYM) ? 3'd2 : 3'd0;
                    err_n   = (tmds != VGUARD_SYM);
                end
                VIDEO: begin
                    mode_n  = 3'd1;
                    video_n = vid;
                end
                DGUARD_LEAD: begin
                    if (is_dguard) begin
                        state_n   = ISLAND;
                        mode_n    = 3'd4;
                        pkt_n     = 5'd0;
                        wrapped_n = 1'b0;
                        did_n     = (CN == 0) ? terc_val : data_island_data;
                        cd_n      = (CN == 0) ? terc_val[1:0] : control_data;
                    end else begin
                        state_n = CTRL;
                        mode_n  = 3'd0;
                        err_n   = 1'b1;
                    end
                end
                ISLAND: begin
                    mode_n    = 3'd3;
                    pkt_n     = pkt + 5'd1;
                    wrapped_n = wrapped | (pkt == 5'd31);
                    if (CN != 0 && wrapped && pkt == 5'd0 && tmds == DGUARD_SYM) begin
                        state_n = DGUARD_TRAIL;
                        mode_n  = 3'd4;
                    end else begin
                        did_n = terc_ok ? terc_val : 4'd0;
                        err_n = ~terc_ok;
                    end
                end
                DGUARD_TRAIL: begin
                    state_n = (tmds == DGUARD_SYM) ? TRAIL_DONE : CTRL;
                    mode_n  = (tmds == DGUARD_SYM) ? 3'd4 : 3'd0;
                    err_n   = (tmds != DGUARD_SYM);
                end
                TRAIL_DONE: mode_n = 3'd4;
                default: begin
                    state_n = CTRL;
                    mode_n  = 3'd0;
                end
            endcase
        end
    end
    always_ff @(posedge clk_pixel or posedge reset) begin
        if (reset) begin
            state            <= CTRL;
            pkt              <= 5'd0;
            wrapped          <= 1'b0;
            mode             <= 3'd0;
            video_data       <= 8'd0;
            data_island_data <= 4'd0;
            control_data     <= 2'd0;
            symbol_error     <= 1'b0;
        end else begin
            state            <= state_n;
            pkt              <= pkt_n;
            wrapped          <= wrapped_n;
            mode             <= mode_n;
            video_data       <= video_n;
            data_island_data <= did_n;
            control_data     <= cd_n;
            symbol_error     <= err_n;
        end
    end
endmodule

// File: tb/tb_tmds_channel_decoder.sv
// tb_tmds_channel_decoder: drives all three channel variants with encoded random payloads
// and compares decoded outputs against the payloads that produced them.
module tb_tmds_channel_decoder;
    logic       clk_pixel = 1'b0;
    logic       reset;
    logic [9:0] tmds;
    logic [1:0] expect_period;
    logic [2:0] mode [3];
    logic [7:0] video_data [3];
    logic [3:0] did [3];
    logic [1:0] cd [3];
    logic       err [3];
    int checks = 0;
    int errors = 0;
    localparam logic [9:0] TERC4 [16] = '{
        10'b1010011100, 10'b1001100011, 10'b1011100100, 10'b1011100010,
        10'b0101110001, 10'b0100011110, 10'b0110001110, 10'b0100111100,
        10'b1011001100, 10'b0100111001, 10'b0110011100, 10'b1011000110,
        10'b1010001110, 10'b1001110001, 10'b0101100011, 10'b1011000011};
    localparam logic [9:0] CTL [4] = '{10'b1101010100, 10'b0010101011, 10'b0101010100, 10'b1010101011};
    localparam logic [9:0] VG [3] = '{10'b1011001100, 10'b0100110011, 10'b1011001100};
    localparam logic [9:0] DG = 10'b0100110011;

    always #5 clk_pixel = ~clk_pixel;

    for (genvar c = 0; c < 3; c++) begin : g_dut
        tmds_channel_decoder #(.CN(c)) dut (
            .clk_pixel(clk_pixel),
            .reset(reset),
            .tmds(tmds),
            .expect_period(expect_period),
            .mode(mode[c]),
            .video_data(video_data[c]),
            .data_island_data(did[c]),
            .control_data(cd[c]),
            .symbol_error(err[c])
        );
    end

    // transition-minimising stage of the transmitter, with a free choice of DC inversion
    function automatic logic [9:0] enc(input logic [7:0] d, input logic inv);
        logic [7:0] q;
        logic xn;
        xn = ($countones(d) > 4) || ($countones(d) == 4 && !d[0]);
        q[0] = d[0];
        for (int i = 1; i < 8; i++) q[i] = xn ? ~(q[i-1] ^ d[i]) : (q[i-1] ^ d[i]);
        return {inv, ~xn, inv ? ~q : q};
    endfunction

    task automatic cyc(input logic [9:0] s);
        @(negedge clk_pixel);
        tmds = s;
        @(posedge clk_pixel);
        #1;
    endtask

    task automatic test_reset;
        reset = 1'b1;
        tmds = CTL[0];
        expect_period = 2'd0;
        repeat (2) @(negedge clk_pixel);
        for (int c = 0; c < 3; c++) begin
            checks++;
            if ({mode[c], video_data[c], did[c], cd[c], err[c]} !== 18'd0) begin
                errors++;
                $display("FAIL reset ch%0d mode=%0d vd=%h did=%h cd=%0d err=%0b required all 0", c, mode[c], video_data[c], did[c], cd[c], err[c]);
            end
        end
        reset = 1'b0;
        repeat (12) begin
            cyc(CTL[0]);
            checks++;
            if (mode[0] !== 3'd0 || cd[0] !== 2'd0 || err[0] !== 1'b0) begin
                errors++;
                $display("FAIL ctrl00 mode=%0d cd=%0d err=%0b required 0 0 0", mode[0], cd[0], err[0]);
            end
        end
        cyc(CTL[1]);
        checks++;
        if (mode[0] !== 3'd0 || cd[0] !== 2'd1) begin
            errors++;
            $display("FAIL ctrl01 mode=%0d cd=%0d required 0 1", mode[0], cd[0]);
        end
    endtask

    task automatic test_video(input int ch);
        logic [7:0] b [20];
        int k;
        b[0] = 8'h00; b[1] = 8'h55; b[2] = 8'hFF; b[3] = 8'h10;
        for (int i = 4; i < 20; i++) b[i] = 8'($urandom);
        cyc(CTL[0]);
        expect_period = 2'd1;
        for (int i = 0; i < 2; i++) begin
            cyc(VG[ch]);
            checks++;
            if (mode[ch] !== 3'd2 || err[ch] !== 1'b0) begin
                errors++;
                $display("FAIL vguard ch%0d #%0d mode=%0d err=%0b required 2 0", ch, i, mode[ch], err[ch]);
            end
        end
        for (int i = 0; i < 20; i++) begin
            cyc(enc(b[i], 1'($urandom)));
            checks++;
            if (mode[ch] !== 3'd1 || video_data[ch] !== b[i] || err[ch] !== 1'b0) begin
                errors++;
                $display("FAIL video ch%0d #%0d mode=%0d vd=%h err=%0b required 1 %h 0", ch, i, mode[ch], video_data[ch], err[ch], b[i]);
            end
        end
        expect_period = 2'd0;
        k = $urandom_range(3);
        cyc(CTL[k]);
        checks++;
        if (mode[ch] !== 3'd0 || cd[ch] !== 2'(k) || video_data[ch] !== b[19]) begin
            errors++;
            $display("FAIL video_end ch%0d mode=%0d cd=%0d vd=%h required 0 %0d %h", ch, mode[ch], cd[ch], video_data[ch], k, b[19]);
        end
    endtask

    task automatic test_island(input int ch);
        logic [3:0] n;
        cyc(CTL[0]);
        expect_period = 2'd2;
        for (int i = 0; i < 2; i++) begin
            cyc(DG);
            checks++;
            if (mode[ch] !== 3'd4 || err[ch] !== 1'b0) begin
                errors++;
                $display("FAIL lead_guard ch%0d #%0d mode=%0d err=%0b required 4 0", ch, i, mode[ch], err[ch]);
            end
        end
        for (int i = 0; i < 32; i++) begin
            n = (ch == 1) ? 4'(i) : 4'($urandom);
            cyc(TERC4[n]);
            checks++;
            if (mode[ch] !== 3'd3 || did[ch] !== n || err[ch] !== 1'b0) begin
                errors++;
                $display("FAIL island ch%0d #%0d mode=%0d did=%h err=%0b required 3 %h 0", ch, i, mode[ch], did[ch], err[ch], n);
            end
        end
        for (int i = 0; i < 5; i++) begin
            cyc(i < 2 ? DG : TERC4[$urandom_range(15)]);
            checks++;
            if (mode[ch] !== 3'd4 || err[ch] !== 1'b0) begin
                errors++;
                $display("FAIL trail ch%0d #%0d mode=%0d err=%0b required 4 0", ch, i, mode[ch], err[ch]);
            end
        end
        expect_period = 2'd0;
        cyc(CTL[1]);
        checks++;
        if (mode[ch] !== 3'd0 || cd[ch] !== 2'd1) begin
            errors++;
            $display("FAIL island_end ch%0d mode=%0d cd=%0d required 0 1", ch, mode[ch], cd[ch]);
        end
    endtask

    task automatic test_island_cn0;
        logic [3:0] n;
        cyc(CTL[0]);
        expect_period = 2'd2;
        n = 4'hF;
        for (int i = 0; i < 2; i++) begin
            cyc(TERC4[n]);
            checks++;
            if (mode[0] !== 3'd4 || cd[0] !== n[1:0] || did[0] !== n || err[0] !== 1'b0) begin
                errors++;
                $display("FAIL cn0_guard #%0d mode=%0d cd=%0d did=%h err=%0b required 4 %0d %h 0", i, mode[0], cd[0], did[0], err[0], n[1:0], n);
            end
            n = {2'b11, 2'($urandom)};
        end
        for (int i = 0; i < 45; i++) begin
            n = (i == 0) ? 4'h0 : 4'($urandom);
            cyc(TERC4[n]);
            checks++;
            if (mode[0] !== 3'd3 || did[0] !== n || err[0] !== 1'b0) begin
                errors++;
                $display("FAIL cn0_island #%0d mode=%0d did=%h err=%0b required 3 %h 0", i, mode[0], did[0], err[0], n);
            end
        end
        expect_period = 2'd0;
        cyc(CTL[2]);
        checks++;
        if (mode[0] !== 3'd0 || cd[0] !== 2'd2) begin
            errors++;
            $display("FAIL cn0_end mode=%0d cd=%0d required 0 2", mode[0], cd[0]);
        end
    endtask

    task automatic test_errors;
        logic [3:0] n;
        cyc(CTL[3]);
        expect_period = 2'd0;
        cyc(VG[0]);
        checks++;
        if (err[0] !== 1'b1 || mode[0] !== 3'd0 || cd[0] !== 2'd3) begin
            errors++;
            $display("FAIL no_expect err=%0b mode=%0d cd=%0d required 1 0 3", err[0], mode[0], cd[0]);
        end
        cyc(CTL[0]);
        checks++;
        if (err[0] !== 1'b0) begin
            errors++;
            $display("FAIL err_pulse err=%0b required 0", err[0]);
        end
        expect_period = 2'd1;
        cyc(VG[0]);
        cyc(enc(8'h3C, 1'b0));
        checks++;
        if (err[0] !== 1'b1 || mode[0] !== 3'd0) begin
            errors++;
            $display("FAIL vguard_short err=%0b mode=%0d required 1 0", err[0], mode[0]);
        end
        expect_period = 2'd2;
        cyc(CTL[0]);
        cyc(DG);
        cyc(TERC4[5]);
        checks++;
        if (err[2] !== 1'b1 || mode[2] !== 3'd0) begin
            errors++;
            $display("FAIL dguard_short err=%0b mode=%0d required 1 0", err[2], mode[2]);
        end
        cyc(CTL[0]);
        cyc(DG);
        cyc(DG);
        for (int i = 0; i < 5; i++) cyc(TERC4[$urandom_range(15)]);
        cyc(10'h3FF);
        checks++;
        if (err[2] !== 1'b1 || did[2] !== 4'd0 || mode[2] !== 3'd3) begin
            errors++;
            $display("FAIL illegal err=%0b did=%h mode=%0d required 1 0 3", err[2], did[2], mode[2]);
        end
        n = 4'($urandom_range(15, 1));
        cyc(TERC4[n]);
        checks++;
        if (err[2] !== 1'b0 || did[2] !== n || mode[2] !== 3'd3) begin
            errors++;
            $display("FAIL after_illegal err=%0b did=%h mode=%0d required 0 %h 3", err[2], did[2], mode[2], n);
        end
        cyc(DG);
        checks++;
        if (err[2] !== 1'b1 || mode[2] !== 3'd3) begin
            errors++;
            $display("FAIL early_guard err=%0b mode=%0d required 1 3", err[2], mode[2]);
        end
        cyc(CTL[0]);
        expect_period = 2'd1;
        cyc(VG[2]);
        cyc(VG[2]);
        cyc(enc(8'hA5, 1'b1));
        #2 reset = 1'b1;
        #1;
        checks++;
        if ({mode[2], video_data[2], did[2], cd[2], err[2]} !== 18'd0) begin
            errors++;
            $display("FAIL async_reset mode=%0d vd=%h did=%h cd=%0d err=%0b required all 0", mode[2], video_data[2], did[2], cd[2], err[2]);
        end
        @(negedge clk_pixel);
        reset = 1'b0;
        cyc(VG[2]);
        checks++;
        if (mode[2] !== 3'd2 || err[2] !== 1'b0) begin
            errors++;
            $display("FAIL post_reset mode=%0d err=%0b required 2 0", mode[2], err[2]);
        end
    endtask

    initial begin
        test_reset;
        for (int c = 0; c < 3; c++) test_video(c);
        test_island(1);
        test_island(2);
        test_island_cn0;
        test_errors;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
